micro_run_ctrl: RTL
===================

# micro_run_ctrl

Run/step/halt sequencer for the `micro` core. It generates the one-cycle `core_en` pulses that advance the core one state (IF→FD→EX→RWB) at a time. It supports free-run at a prescaled rate, single-instruction stepping from a debounced push button, a PC breakpoint, and latching of the HLT instruction. It sits between the board-level wrapper (switches and keys) and the core, and replaces ad-hoc clock muxing with a clean clock enable.

## Interface
Parameters:
- `TICK_MAX`, default 2500000: prescaler terminal count. The run tick period is TICK_MAX+1 cycles.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples required to accept a new input level.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run_sw`  in  1  raw switch: 1 = run, 0 = stop.
- `step_key`  in  1  raw push button, active-low.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  8  breakpoint PC.
- `pc`  in  8  core PC.
- `core_state`  in  2  core state: 00 IF, 01 FD, 10 EX, 11 RWB.
- `opcode`  in  4  core OPCODE.
- `core_en`  out  1  core clock enable, one cycle per core state advance.
- `mode`  out  2  controller state: 00 STOP, 01 RUN, 10 STEP, 11 HALT.
- `halted`  out  1  HLT retired.
- `bp_hit`  out  1  stopped at the breakpoint.
- `instr_count`  out  16  retired instruction count.

## Operation
Input conditioning:
- Each raw input passes through a 2-flop synchronizer, then a debounce counter.
- The debounced level updates only after DEBOUNCE_CYCLES consecutive cycles of a synchronized level that differs from it.
- Events, each a single-cycle strobe:
  - `step_press`: debounced step_key falls 1→0.
  - `run_rise`: debounced run_sw rises 0→1.
  - `run_fall`: debounced run_sw falls 1→0.

Prescaler:
- Free-running counter from 0 to TICK_MAX.
- `tick` is high for one cycle when the count equals TICK_MAX; the counter then returns to 0.

Retire and halt detection:
- A retire occurs on any cycle with core_en=1 and core_state=RWB. Each retire increments instr_count, which wraps from FFFF to 0000.
- A HLT is a retire with opcode=F.

Breakpoint:
- `bp_match` = bp_en & (pc==bp_addr) & (core_state==IF) & ~bp_skip.
- `bp_skip` is set on entry to RUN or STEP.
- `bp_skip` is cleared on the first core_en issued with core_state=IF.

core_en:
- RUN: core_en = tick & ~bp_match.
- STEP: core_en = 1 every cycle.
- STOP and HALT: core_en = 0.

FSM transitions, listed in priority order:
- Any state → HALT on a HLT retire. HALT is exited only by reset. In HALT, sets `halted`=1.
- RUN → STOP on tick & bp_match. Sets bp_hit=1. No core_en is issued that cycle.
- RUN → STOP on run_fall. The stop is immediate and may land mid-instruction.
- STEP → STOP on a retire. A step therefore completes the current instruction; from IF that is exactly 4 pulses.
- STOP → RUN on run_rise. Clears bp_hit.
- STOP → STEP on step_press with debounced run_sw=0. Clears bp_hit.
- step_press in RUN or STEP is ignored.
- run_rise in STEP is ignored.

## Timing
- Reset values (applied asynchronously while reset=0):
  - mode=STOP, core_en=0, halted=0, bp_hit=0, instr_count=0.
  - Prescaler = 0, bp_skip = 0.
  - Synchronizer and debounced step_key = 1; synchronizer and debounced run_sw = 0.
  - Debounce counters = 0.
- Latency from a raw edge to its event strobe: 2 sync cycles + DEBOUNCE_CYCLES, ±1 cycle.
- The mode change is registered on the clock edge after the event.
- core_en is combinational from registered mode, tick, bp_skip and the core inputs. The core samples it on the same edge.
- STEP started with core_state=IF:
  - core_en is high for 4 consecutive cycles.
  - mode=STOP on the cycle after the RWB pulse.
  - instr_count increments on the same edge as the RWB pulse.
- RUN: one core_en per TICK_MAX+1 cycles. The first pulse comes at the next tick after entry; the prescaler is not restarted on entry.
- Simultaneous events in one cycle: HLT retire beats bp_match, which beats run_fall. Stepping only ever starts from STOP.
- Reset asserted mid-step or mid-run forces reset values immediately. No further core_en is issued.

## Test plan
Bench parameters: TICK_MAX=3, DEBOUNCE_CYCLES=4. The core is a behavioural model that advances core_state on core_en.

1. Reset: drive reset=0 between clock edges during RUN.
   - Required: all outputs at reset values immediately.
   - Required: mode=00 and instr_count=0000 after release.
2. Debounce and step:
   - step_key low for 2 cycles → no event, no core_en.
   - step_key low for 12 cycles with model at IF → exactly 4 consecutive core_en pulses, instr_count=1, mode returns to 00.
3. Run: run_sw 0→1.
   - Required: core_en on every 4th cycle.
   - Required: after 8 pulses, instr_count=2.
   - run_sw→0 mid-instruction → core_en stops. A subsequent step press finishes the instruction with the remaining pulses only.
4. Breakpoint: bp_en=1, bp_addr=05, run until the model reaches pc=05 at IF.
   - Required: no core_en, bp_hit=1, mode=00.
   - Toggle run_sw 0→1 → bp_hit=0, and the instruction at 05 executes without re-trigger.
5. Halt: model presents opcode=F on a RWB pulse in RUN.
   - Required: halted=1 and mode=11 on the next cycle.
   - Required: no core_en despite run toggles or step presses until reset.
6. Wrap: with TICK_MAX=0, run 65536 instructions.
   - Required: instr_count wraps FFFF→0000, with no missed or extra increment.

Source files
------------

// File: rtl/micro_run_ctrl.sv
// Run/step/halt sequencer for the micro core: conditions the board inputs and issues one-cycle
// core clock enables for free-run, single-step, breakpoint stop and HLT latching.
module micro_run_ctrl #(
  parameter int unsigned TICK_MAX        = 2500000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_key,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  input  logic [1:0]  core_state,
  input  logic [3:0]  opcode,
  output logic        core_en,
  output logic [1:0]  mode,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] instr_count
);

  localparam int unsigned TickW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(TICK_MAX);

  typedef enum logic [1:0] {
    StStop = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [1:0]       step_sync_q, run_sync_q;
  logic             step_db_q, step_db_d, run_db_q, run_db_d;
  logic [DbW-1:0]   step_cnt_q, step_cnt_d, run_cnt_q, run_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             bp_hit_q, bp_hit_d, bp_skip_q, bp_skip_d;
  logic [15:0]      instr_count_q, instr_count_d;

  logic step_diff, run_diff, step_flip, run_flip;
  logic step_press, run_rise, run_fall;
  logic tick, bp_match, core_is_if, core_is_rwb, retire, hlt_retire;

  // A debounced level flips on the last of DEBOUNCE_CYCLES differing samples; that cycle is the
  // event strobe.
  assign step_diff  = step_sync_q[1] != step_db_q;
  assign run_diff   = run_sync_q[1] != run_db_q;
  assign step_flip  = step_diff && (step_cnt_q == DbLast);
  assign run_flip   = run_diff && (run_cnt_q == DbLast);
  assign step_press = step_flip & step_db_q;
  assign run_rise   = run_flip & ~run_db_q;
  assign run_fall   = run_flip & run_db_q;

  always_comb begin
    step_cnt_d = '0;
    run_cnt_d  = '0;
    if (step_diff && !step_flip) step_cnt_d = step_cnt_q + DbW'(1);
    if (run_diff && !run_flip)   run_cnt_d  = run_cnt_q + DbW'(1);
    step_db_d = step_flip ? step_sync_q[1] : step_db_q;
    run_db_d  = run_flip ? run_sync_q[1] : run_db_q;
  end

  assign tick       = tick_cnt_q == TickEnd;
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

  assign core_is_if  = core_state == 2'b00;
  assign core_is_rwb = core_state == 2'b11;
  assign bp_match    = bp_en & (pc == bp_addr) & core_is_if & ~bp_skip_q;

  always_comb begin
    case (mode_q)
      StRun:   core_en = tick & ~bp_match;
      StStep:  core_en = 1'b1;
      default: core_en = 1'b0;
    endcase
  end

  assign retire     = core_en & core_is_rwb;
  assign hlt_retire = retire & (opcode == 4'hF);

  always_comb begin
    mode_d        = mode_q;
    bp_hit_d      = bp_hit_q;
    bp_skip_d     = bp_skip_q;
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + 16'd1;
    // The skip lets a resumed run/step leave the breakpoint PC without re-triggering on it.
    if (core_en && core_is_if) bp_skip_d = 1'b0;
    if (hlt_retire) begin
      mode_d = StHalt;
    end else begin
      case (mode_q)
        StRun: begin
          if (tick && bp_match) begin
            mode_d   = StStop;
            bp_hit_d = 1'b1;
          end else if (run_fall) begin
            mode_d = StStop;
          end
        end
        StStep: begin
          if (retire) mode_d = StStop;
        end
        StStop: begin
          if (run_rise) begin
            mode_d    = StRun;
            bp_hit_d  = 1'b0;
            bp_skip_d = 1'b1;
          end else if (step_press && !run_db_q) begin
            mode_d    = StStep;
            bp_hit_d  = 1'b0;
            bp_skip_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_sync_q   <= 2'b11;
      run_sync_q    <= 2'b00;
      step_db_q     <= 1'b1;
      run_db_q      <= 1'b0;
      step_cnt_q    <= '0;
      run_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      mode_q        <= StStop;
      bp_hit_q      <= 1'b0;
      bp_skip_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      step_sync_q   <= {step_sync_q[0], step_key};
      run_sync_q    <= {run_sync_q[0], run_sw};
      step_db_q     <= step_db_d;
      run_db_q      <= run_db_d;
      step_cnt_q    <= step_cnt_d;
      run_cnt_q     <= run_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      mode_q        <= mode_d;
      bp_hit_q      <= bp_hit_d;
      bp_skip_q     <= bp_skip_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign mode        = mode_q;
  assign halted      = mode_q == StHalt;
  assign bp_hit      = bp_hit_q;
  assign instr_count = instr_count_q;

endmodule
